// File: rtl/mont_exp_ctrl.sv
// Right-to-left binary exponentiation sequencer driving an external Montgomery
// product unit. Define MONT_EXP_EARLY_TERM_EN to stop once the remaining exponent bits are zero.
module mont_exp_ctrl #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_n,
  input  logic [WIDTH-1:0] i_y,
  input  logic [WIDTH-1:0] i_d,
  output logic             o_mp_start,
  output logic [WIDTH-1:0] o_mp_n,
  output logic [WIDTH-1:0] o_mp_a,
  output logic [WIDTH-1:0] o_mp_b,
  input  logic [WIDTH-1:0] i_mp_m,
  input  logic             i_mp_finish,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_result,
  output logic             o_finish
);

  localparam int unsigned IDXW = $clog2(WIDTH) + 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    M_REQ,
    M_WAIT,
    T_REQ,
    T_WAIT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] d_r;
  logic [WIDTH-1:0] t_r;
  logic [WIDTH-1:0] m_r;
  logic [IDXW-1:0]  idx;
  logic [IDXW-1:0]  idx_nxt;
  logic             d_nxt_bit;
  logic             start_zero;
  logic             early_done;

  // Index truncation only matters when idx_nxt == WIDTH, where we go to DONE anyway.
  assign idx_nxt   = idx + 1'b1;
  assign d_nxt_bit = d_r[idx_nxt[IDXW-2:0]];

`ifdef MONT_EXP_EARLY_TERM_EN
  assign start_zero = (i_d == '0);
  assign early_done = ((d_r >> idx_nxt) == '0);
`else
  assign start_zero = 1'b0;
  assign early_done = 1'b0;
`endif

  // The start pulse and operands are loaded on entry to M_REQ/T_REQ, so the
  // pulse is visible during the request state itself and operands hold until finish.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      d_r        <= '0;
      t_r        <= '0;
      m_r        <= '0;
      idx        <= '0;
      o_mp_start <= 1'b0;
      o_mp_n     <= '0;
      o_mp_a     <= '0;
      o_mp_b     <= '0;
      o_busy     <= 1'b0;
      o_result   <= '0;
      o_finish   <= 1'b0;
    end else begin
      o_mp_start <= 1'b0;
      o_finish   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_start) begin
            d_r    <= i_d;
            t_r    <= i_y;
            m_r    <= WIDTH'(1);
            idx    <= '0;
            o_mp_n <= i_n;
            o_busy <= 1'b1;
            if (start_zero) begin
              state <= DONE;
            end else if (i_d[0]) begin
              state      <= M_REQ;
              o_mp_start <= 1'b1;
              o_mp_a     <= WIDTH'(1);
              o_mp_b     <= i_y;
            end else begin
              state      <= T_REQ;
              o_mp_start <= 1'b1;
              o_mp_a     <= i_y;
              o_mp_b     <= i_y;
            end
          end
        end
        M_REQ: state <= M_WAIT;
        T_REQ: state <= T_WAIT;
        M_WAIT: begin
          if (i_mp_finish) begin
            m_r <= i_mp_m;
            if (early_done) begin
              state <= DONE;
            end else begin
              state      <= T_REQ;
              o_mp_start <= 1'b1;
              o_mp_a     <= t_r;
              o_mp_b     <= t_r;
            end
          end
        end
        T_WAIT: begin
          if (i_mp_finish) begin
            t_r <= i_mp_m;
            idx <= idx_nxt;
            if (idx == LAST_IDX || early_done) begin
              state <= DONE;
            end else if (d_nxt_bit) begin
              state      <= M_REQ;
              o_mp_start <= 1'b1;
              o_mp_a     <= m_r;
              o_mp_b     <= i_mp_m;
            end else begin
              state      <= T_REQ;
              o_mp_start <= 1'b1;
              o_mp_a     <= i_mp_m;
              o_mp_b     <= i_mp_m;
            end
          end
        end
        DONE: begin
          o_result <= m_r;
          o_finish <= 1'b1;
          o_busy   <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Directed bench for mont_exp_ctrl with a randomized-latency Montgomery product
// responder; expected results are hand-computed for N=13 (2^256 mod 13 = 3).
module tb_mont_exp_ctrl;

  localparam int W      = 256;
  localparam int MAXCYC = 90000;
`ifdef MONT_EXP_EARLY_TERM_EN
  localparam int P_D3     = 3;
  localparam int P_D10001 = 18;
  localparam int P_D0     = 0;
`else
  localparam int P_D3     = 258;
  localparam int P_D10001 = 258;
  localparam int P_D0     = 256;
`endif

  logic         clk     = 1'b0;
  logic         rst     = 1'b1;
  logic         i_start = 1'b0;
  logic [W-1:0] i_n     = '0;
  logic [W-1:0] i_y     = '0;
  logic [W-1:0] i_d     = '0;
  logic         o_mp_start;
  logic [W-1:0] o_mp_n;
  logic [W-1:0] o_mp_a;
  logic [W-1:0] o_mp_b;
  logic [W-1:0] i_mp_m      = '0;
  logic         i_mp_finish = 1'b0;
  logic         o_busy;
  logic [W-1:0] o_result;
  logic         o_finish;

  int checks       = 0;
  int errors       = 0;
  int pulses       = 0;
  int stab_viol    = 0;
  int overlap_viol = 0;
  int stale_req    = 0;
  int stale_done   = 0;
  bit pending      = 1'b0;
  int lat          = 0;
  logic [W-1:0] cap_a = '0;
  logic [W-1:0] cap_b = '0;
  logic [W-1:0] cap_n = '0;
  logic [W-1:0] cap_m = '0;

  mont_exp_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_n         (i_n),
    .i_y         (i_y),
    .i_d         (i_d),
    .o_mp_start  (o_mp_start),
    .o_mp_n      (o_mp_n),
    .o_mp_a      (o_mp_a),
    .o_mp_b      (o_mp_b),
    .i_mp_m      (i_mp_m),
    .i_mp_finish (i_mp_finish),
    .o_busy      (o_busy),
    .o_result    (o_result),
    .o_finish    (o_finish)
  );

  always #5 clk = ~clk;

  // Bit-serial Montgomery product: a*b*2^-W mod n for odd n, a,b < n.
  function automatic logic [W-1:0] mont(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] n);
    logic [W+1:0] x;
    x = '0;
    for (int i = 0; i < W; i++) begin
      if (a[i]) x = x + {2'b00, b};
      if (x[0]) x = x + {2'b00, n};
      x = x >> 1;
    end
    if (x >= {2'b00, n}) x = x - {2'b00, n};
    return x[W-1:0];
  endfunction

  // Product unit model: shares rst, answers after 1..300 cycles, watches operand stability.
  initial begin
    forever begin
      @(negedge clk);
      i_mp_finish = 1'b0;
      if (rst) begin
        pending = 1'b0;
      end else if (stale_done != stale_req) begin
        stale_done++;
        i_mp_finish = 1'b1;
        i_mp_m      = W'(11);
      end else if (pending) begin
        if (o_mp_a !== cap_a || o_mp_b !== cap_b || o_mp_n !== cap_n) stab_viol++;
        if (o_mp_start) overlap_viol++;
        if (lat <= 1) begin
          i_mp_finish = 1'b1;
          i_mp_m      = cap_m;
          pending     = 1'b0;
        end else begin
          lat--;
        end
      end else if (o_mp_start) begin
        pulses++;
        cap_a   = o_mp_a;
        cap_b   = o_mp_b;
        cap_n   = o_mp_n;
        cap_m   = mont(o_mp_a, o_mp_b, o_mp_n);
        lat     = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 300))
                                               : int'($urandom_range(1, 4));
        pending = 1'b1;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"},  W'(o_busy), W'(0));
    check({tag, "_start"}, W'(o_mp_start), W'(0));
    check({tag, "_fin"},   W'(o_finish), W'(0));
    check({tag, "_res"},   o_result, W'(0));
    check({tag, "_a"},     o_mp_a, W'(0));
    check({tag, "_b"},     o_mp_b, W'(0));
    check({tag, "_n"},     o_mp_n, W'(0));
  endtask

  task automatic run(input string tag, input logic [W-1:0] n, input logic [W-1:0] y,
                     input logic [W-1:0] d, input logic [W-1:0] exp_res,
                     input int exp_pulses, output int cyc);
    int p0, s0, o0;
    bit done;
    p0 = pulses;
    s0 = stab_viol;
    o0 = overlap_viol;
    i_n = n;
    i_y = y;
    i_d = d;
    i_start = 1'b1;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < MAXCYC) begin
      tick();
      cyc++;
      i_start = 1'b0;
      if (o_finish) done = 1'b1;
    end
    check({tag, "_done"},    W'(done), W'(1));
    check({tag, "_result"},  o_result, exp_res);
    check({tag, "_idle"},    W'(o_busy), W'(0));
    check({tag, "_pulses"},  W'(pulses - p0), W'(exp_pulses));
    check({tag, "_stable"},  W'(stab_viol - s0), W'(0));
    check({tag, "_overlap"}, W'(overlap_viol - o0), W'(0));
    tick();
    check({tag, "_finpulse"}, W'(o_finish), W'(0));
    check({tag, "_held"},     o_result, exp_res);
  endtask

  initial begin
    int cyc, p0, s0, o0, bad;
    bit found;

    repeat (3) tick();
    check_reset("reset");
    rst = 1'b0;
    tick();

    run("d3", W'(13), W'(6), W'(3), W'(8), P_D3, cyc);
    run("d10001", W'(13), W'(2), W'('h10001), W'(5), P_D10001, cyc);
    run("d0", W'(13), W'(6), W'(0), W'(1), P_D0, cyc);
`ifdef MONT_EXP_EARLY_TERM_EN
    check("d0_latency", W'(cyc), W'(2));
`endif
    repeat (5) tick();
    check("result_hold", o_result, W'(1));

    // Start pokes and operand changes while busy must not disturb the run.
    p0 = pulses;
    s0 = stab_viol;
    o0 = overlap_viol;
    bad = 0;
    found = 1'b0;
    cyc = 0;
    i_n = W'(13);
    i_y = W'(6);
    i_d = W'(3);
    i_start = 1'b1;
    while (!found && cyc < MAXCYC) begin
      tick();
      cyc++;
      if (o_finish) begin
        found = 1'b1;
      end else begin
        if (!o_busy) bad++;
        i_start = ~i_start;
        i_n = W'(7);
        i_y = W'(4);
        i_d = W'(5);
      end
    end
    check("busy_done",    W'(found), W'(1));
    check("busy_result",  o_result, W'(8));
    check("busy_pulses",  W'(pulses - p0), W'(P_D3));
    check("busy_stable",  W'(stab_viol - s0), W'(0));
    check("busy_overlap", W'(overlap_viol - o0), W'(0));
    check("busy_nodrop",  W'(bad), W'(0));

    // Request raised in the first IDLE cycle is taken immediately.
    p0 = pulses;
    i_n = W'(13);
    i_y = W'(2);
    i_d = W'('h10001);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("restart_busy",  W'(o_busy), W'(1));
    check("restart_start", W'(o_mp_start), W'(1));
    check("restart_a",     o_mp_a, W'(1));
    check("restart_b",     o_mp_b, W'(2));
    check("restart_n",     o_mp_n, W'(13));

    // Second product of this run is a squaring; reset while it is outstanding.
    found = 1'b0;
    cyc = 0;
    while (!found && cyc < MAXCYC) begin
      tick();
      cyc++;
      if ((pulses - p0) == 2 && !o_mp_start && o_busy) found = 1'b1;
    end
    check("twait_seen", W'(found), W'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset("midrst");

    stale_req++;
    bad = 0;
    repeat (6) begin
      tick();
      if (o_busy || o_finish || o_mp_start) bad++;
    end
    check("stale_sent",    W'(stale_done), W'(1));
    check("stale_ignored", W'(bad), W'(0));
    check("stale_result",  o_result, W'(0));

    run("after_rst", W'(13), W'(6), W'(3), W'(8), P_D3, cyc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mont_exp_ctrl.md
MONT_EXP_CTRL -- requirements
Module: mont_exp_ctrl

Interface
REQ-001 Parameter: WIDTH, 256, operand/modulus/exponent width in bits.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 i_start  in  1  request; sampled only in IDLE.
REQ-005 i_n  in  WIDTH  modulus N, odd, N < 2^WIDTH.
REQ-006 i_y  in  WIDTH  base already in Montgomery form (y*2^WIDTH mod N).
REQ-007 i_d  in  WIDTH  exponent d.
REQ-008 o_mp_start  out  1  one-cycle start pulse to the external Montgomery product unit.
REQ-009 o_mp_n / o_mp_a / o_mp_b  out  WIDTH each  operands N, a, b for the product unit.
REQ-010 i_mp_m  in  WIDTH  product result a*b*2^-WIDTH mod N.
REQ-011 i_mp_finish  in  1  one-cycle pulse; i_mp_m is valid in that cycle.
REQ-012 o_busy  out  1  high in every state except IDLE.
REQ-013 o_result  out  WIDTH  y^d mod N in normal (non-Montgomery) form.
REQ-014 o_finish  out  1  one-cycle pulse; o_result is valid in that cycle.

Function
REQ-015 States SHALL be IDLE, M_REQ, M_WAIT, T_REQ, T_WAIT, DONE.
REQ-016 IDLE with i_start=1 SHALL latch i_n, i_y, i_d; set t=i_y, m=1, bit index i=0; then go to M_REQ if d[0]=1, else T_REQ.
REQ-017 M_REQ SHALL drive o_mp_start=1 for exactly one cycle with a=m, b=t, then go to M_WAIT.
REQ-018 M_WAIT on i_mp_finish SHALL set m=i_mp_m, then go to T_REQ (unless REQ-032 applies).
REQ-019 T_REQ SHALL pulse o_mp_start once with a=t, b=t, then go to T_WAIT.
REQ-020 T_WAIT on i_mp_finish SHALL set t=i_mp_m and increment i. If i was WIDTH-1, go to DONE. Otherwise go to M_REQ if d[i+1]=1, else T_REQ.
REQ-021 DONE SHALL set o_result=m, pulse o_finish for one cycle, and return to IDLE.
REQ-022 o_mp_n, o_mp_a, o_mp_b SHALL be registered and held stable from the o_mp_start cycle until the matching i_mp_finish.
REQ-023 o_mp_start SHALL rise in the cycle after the request is accepted, and never while an operation is outstanding.
REQ-024 i_mp_finish outside M_WAIT/T_WAIT SHALL be ignored. The controller SHALL wait indefinitely for finish; there is no timeout.
REQ-025 i_start while busy SHALL be ignored. Latched operands SHALL not change mid-operation.
REQ-026 i_start in the DONE→IDLE return cycle SHALL be accepted on the next IDLE cycle only.
REQ-027 o_result SHALL hold its value until the next DONE. For d=0, o_result SHALL be 1.
REQ-028 The bit index counter SHALL be ceil(log2(WIDTH))+1 bits wide and SHALL never wrap.

Reset
REQ-029 rst SHALL force state=IDLE, o_busy=0, o_mp_start=0, o_finish=0, o_result=0, and clear m, t, i and all operand registers to 0, taking effect on the same clock edge.
REQ-030 rst mid-operation SHALL abandon the operation. A later i_mp_finish from the abandoned operation SHALL be ignored per REQ-024. The product unit shares rst.

Configuration
REQ-031 Macro MONT_EXP_EARLY_TERM_EN SHALL select early termination.
REQ-032 With the macro defined: when the remaining exponent bits d>>(i+1) are all zero at the end of M_WAIT or T_WAIT, go directly to DONE, skipping the remaining squarings. For d=0, go IDLE→DONE with no product requests.
REQ-033 With the macro undefined: always process all WIDTH bits per REQ-020. o_result SHALL be identical in both builds; only the operation count differs.

Verification
REQ-034 N=13, i_y=6 (y=2), d=3 → o_result=8. Macro off: 258 o_mp_start pulses. Macro on: 3 pulses.
REQ-035 N=13, i_y=2 (y=5), d=0x10001 → o_result=5.
REQ-036 N=13, i_y=6, d=0 → o_result=1. Macro off: 256 pulses. Macro on: 0 pulses, and o_finish 2 cycles after start.
REQ-037 Assert i_start repeatedly during busy, and change i_n/i_d mid-run → no restart; result matches the originally latched operands.
REQ-038 Assert rst during T_WAIT, then inject a stale i_mp_finish → outputs at reset values; stale finish ignored; a new request runs correctly.
REQ-039 Model product latency randomized 1..300 cycles → o_mp_a/b/n stable across each wait; o_mp_start never overlaps an outstanding operation.
